// File: rtl/pll_reset_pkg.sv
// Shared types and sizing helpers for the PLL-driven staged reset sequencer.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    // Width needed to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Generic single-bit synchroniser: STAGES flops in series, synchronous active-low clear to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic sresetn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i) begin
        if (!sresetn_i) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock into an ordered, spaced release of per-domain
// synchronous resets, and reasserts all of them at once when lock is lost.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int NUM_DOMAINS        = 3,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP_CYCLES = 16,
    parameter int LOSS_CNT_WIDTH     = 8
) (
    input  logic                      clk_i,
    input  logic                      sresetn_i,
    input  logic                      pll_locked_i,
    input  logic                      clear_sticky_i,
    output logic [NUM_DOMAINS-1:0]    domain_sresetn_o,
    output logic                      all_ready_o,
    output logic                      lock_ok_o,
    output logic                      lock_lost_sticky_o,
    output logic [LOSS_CNT_WIDTH-1:0] lock_loss_count_o
);

    localparam int STAB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int GAP_W  = cnt_width(RELEASE_GAP_CYCLES);
    localparam int IDX_W  = cnt_width(NUM_DOMAINS);

    localparam logic [STAB_W-1:0]         STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0]         STAB_ONE  = STAB_W'(1);
    localparam logic [GAP_W-1:0]          GAP_LAST  = GAP_W'(RELEASE_GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]          GAP_ONE   = GAP_W'(1);
    localparam logic [IDX_W-1:0]          IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0]          IDX_ONE   = IDX_W'(1);
    localparam logic [LOSS_CNT_WIDTH-1:0] CNT_MAX   = {LOSS_CNT_WIDTH{1'b1}};
    localparam logic [LOSS_CNT_WIDTH-1:0] CNT_ONE   = LOSS_CNT_WIDTH'(1);

    pll_state_e                state_q, state_d;
    logic [STAB_W-1:0]         stab_q, stab_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0]    dom_q, dom_d;
    logic                      ready_q, ready_d;
    logic                      sticky_q, sticky_d;
    logic [LOSS_CNT_WIDTH-1:0] loss_cnt_q, loss_cnt_d;
    logic                      loss_ev_s;
    logic                      lock_ok_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i     (clk_i),
        .sresetn_i (sresetn_i),
        .d_i       (pll_locked_i),
        .q_o       (lock_ok_s)
    );

    // Sequencer next state: stabilisation count, staged release, loss handling.
    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        dom_d     = dom_q;
        ready_d   = ready_q;
        loss_ev_s = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                dom_d   = {NUM_DOMAINS{1'b0}};
                ready_d = 1'b0;
                stab_d  = {STAB_W{1'b0}};
                gap_d   = {GAP_W{1'b0}};
                idx_d   = {IDX_W{1'b0}};
                if (lock_ok_s) begin
                    state_d = STABILISE;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end

            STABILISE: begin
                if (!lock_ok_s) begin
                    state_d = WAIT_LOCK;
                    stab_d  = {STAB_W{1'b0}};
                end else if (stab_q == STAB_LAST) begin
                    dom_d    = {NUM_DOMAINS{1'b0}};
                    dom_d[0] = 1'b1;
                    stab_d   = {STAB_W{1'b0}};
                    gap_d    = {GAP_W{1'b0}};
                    idx_d    = IDX_ONE;
                    if (NUM_DOMAINS == 1) begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    stab_d = stab_q + STAB_ONE;
                end
            end

            RELEASE: begin
                if (!lock_ok_s) begin
                    loss_ev_s = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    // Releases only ever extend the thermometer of low indices.
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (k == int'(idx_q)) begin
                            dom_d[k] = 1'b1;
                        end else begin
                            dom_d[k] = dom_q[k];
                        end
                    end
                    gap_d = {GAP_W{1'b0}};
                    idx_d = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end

            RUN: begin
                if (!lock_ok_s) begin
                    loss_ev_s = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                dom_d   = {NUM_DOMAINS{1'b0}};
                ready_d = 1'b0;
            end
        endcase

        if (loss_ev_s) begin
            state_d = WAIT_LOCK;
            dom_d   = {NUM_DOMAINS{1'b0}};
            ready_d = 1'b0;
            stab_d  = {STAB_W{1'b0}};
            gap_d   = {GAP_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
        end else begin
            state_d = state_d;
        end
    end

    // Loss bookkeeping: a loss on the same edge as a clear keeps the sticky set.
    always_comb begin
        sticky_d   = sticky_q;
        loss_cnt_d = loss_cnt_q;
        if (loss_ev_s) begin
            sticky_d = 1'b1;
        end else if (clear_sticky_i) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
        if (loss_ev_s && (loss_cnt_q != CNT_MAX)) begin
            loss_cnt_d = loss_cnt_q + CNT_ONE;
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!sresetn_i) begin
            state_q    <= WAIT_LOCK;
            stab_q     <= {STAB_W{1'b0}};
            gap_q      <= {GAP_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            dom_q      <= {NUM_DOMAINS{1'b0}};
            ready_q    <= 1'b0;
            sticky_q   <= 1'b0;
            loss_cnt_q <= {LOSS_CNT_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            stab_q     <= stab_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            dom_q      <= dom_d;
            ready_q    <= ready_d;
            sticky_q   <= sticky_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign domain_sresetn_o   = dom_q;
    assign all_ready_o        = ready_q;
    assign lock_ok_o          = lock_ok_s;
    assign lock_lost_sticky_o = sticky_q;
    assign lock_loss_count_o  = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with N=2, L=4, G=3, three domains, 2-bit loss counter.
module tb_pll_reset_sequencer;

    localparam int N    = 2;
    localparam int L    = 4;
    localparam int G    = 3;
    localparam int D    = 3;
    localparam int REL0 = N + 1 + L;

    logic       clk;
    logic       sresetn;
    logic       pll_locked;
    logic       clear_sticky;
    logic [2:0] domain_sresetn;
    logic       all_ready;
    logic       lock_ok;
    logic       lock_lost_sticky;
    logic [1:0] lock_loss_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       rstn;
        logic       pll;
        logic       clr;
        logic [2:0] dom;
        logic       ready;
        logic       lock;
        logic       sticky;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs[21];

    pll_reset_sequencer #(
        .NUM_DOMAINS        (D),
        .SYNC_STAGES        (N),
        .LOCK_STABLE_CYCLES (L),
        .RELEASE_GAP_CYCLES (G),
        .LOSS_CNT_WIDTH     (2)
    ) dut (
        .clk_i              (clk),
        .sresetn_i          (sresetn),
        .pll_locked_i       (pll_locked),
        .clear_sticky_i     (clear_sticky),
        .domain_sresetn_o   (domain_sresetn),
        .all_ready_o        (all_ready),
        .lock_ok_o          (lock_ok),
        .lock_lost_sticky_o (lock_lost_sticky),
        .lock_loss_count_o  (lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] dom, input logic ready,
                             input logic lock, input logic sticky, input logic [1:0] cnt);
        check({tag, ".dom"},    32'(domain_sresetn),   32'(dom));
        check({tag, ".ready"},  32'(all_ready),        32'(ready));
        check({tag, ".lock"},   32'(lock_ok),          32'(lock));
        check({tag, ".sticky"}, 32'(lock_lost_sticky), 32'(sticky));
        check({tag, ".cnt"},    32'(lock_loss_count),  32'(cnt));
    endtask

    // Lock held from a clean WAIT_LOCK; edge e expectations from the release formula.
    task automatic nominal(input string tag, input logic sticky, input logic [1:0] cnt);
        logic [2:0] dom;
        for (int e = 1; e <= REL0 + (D - 1) * G; e++) begin
            pll_locked = 1'b1;
            step();
            for (int k = 0; k < D; k++) dom[k] = (e >= REL0 + k * G);
            check_all($sformatf("%s.e%0d", tag, e), dom, (e >= REL0 + (D - 1) * G),
                      (e >= N), sticky, cnt);
        end
    endtask

    // Lose lock right after domain 0 released; the loss lands on the edge a release was due.
    task automatic loss_mid_release(input string tag, input logic [1:0] cnt);
        for (int e = 1; e <= REL0; e++) begin
            pll_locked = 1'b1;
            step();
            if (e == REL0 - 1) check({tag, ".pre0"}, 32'(domain_sresetn), 32'(3'b000));
        end
        check({tag, ".rel0"}, 32'(domain_sresetn), 32'(3'b001));
        pll_locked = 1'b0;
        step();
        step();
        check({tag, ".hold"}, 32'(domain_sresetn), 32'(3'b001));
        step();
        check_all({tag, ".loss"}, 3'b000, 1'b0, 1'b0, 1'b1, cnt);
    endtask

    initial begin
        sresetn      = 1'b0;
        pll_locked   = 1'b0;
        clear_sticky = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0};
        for (int i = 3; i <= 7; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0};
        for (int i = 8; i <= 10; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 2'd0};
        for (int i = 11; i <= 13; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1};

        // Reset, nominal release, loss in RUN, lone clear_sticky.
        for (int i = 0; i < 21; i++) begin
            sresetn      = vecs[i].rstn;
            pll_locked   = vecs[i].pll;
            clear_sticky = vecs[i].clr;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].dom, vecs[i].ready, vecs[i].lock,
                      vecs[i].sticky, vecs[i].cnt);
        end
        clear_sticky = 1'b0;

        nominal("relock", 1'b0, 2'd1);

        // Loss and clear_sticky on the same edge: loss wins.
        pll_locked = 1'b0;
        step();
        step();
        check("clrloss.pre", 32'(domain_sresetn), 32'(3'b111));
        clear_sticky = 1'b1;
        step();
        check_all("clrloss", 3'b000, 1'b0, 1'b0, 1'b1, 2'd2);
        step();
        check("clralone.sticky", 32'(lock_lost_sticky), 32'(1'b0));
        check("clralone.cnt", 32'(lock_loss_count), 32'(2'd2));
        clear_sticky = 1'b0;

        // Lock drops during STABILISE: no loss, no release.
        pll_locked = 1'b1;
        step();
        step();
        step();
        pll_locked = 1'b0;
        for (int e = 4; e <= 7; e++) begin
            step();
            check_all($sformatf("stabdrop.e%0d", e), 3'b000, 1'b0, (e == 4), 1'b0, 2'd2);
        end
        nominal("stabrelock", 1'b0, 2'd2);

        // sresetn pulse in RUN with lock still held.
        sresetn = 1'b0;
        step();
        check_all("srst", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
        sresetn = 1'b1;
        nominal("postrst", 1'b0, 2'd0);

        pll_locked = 1'b0;
        step();
        step();
        step();
        check_all("runloss", 3'b000, 1'b0, 1'b0, 1'b1, 2'd1);

        // Four more losses mid-RELEASE: counter saturates at 3.
        for (int i = 0; i < 4; i++) begin
            loss_mid_release($sformatf("midrel%0d", i), (i == 0) ? 2'd2 : 2'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
